// File: rtl/rom_fetch_unit_if.sv
// rtl/rom_fetch_unit_if.sv - ROM read port and decoder byte stream of the fetch unit
interface rom_fetch_unit_if;
    logic [7:0] ROM_ADDR;
    logic [7:0] ROM_DATA;
    logic       JUMP;
    logic [7:0] JUMP_ADDR;
    logic [7:0] INSTR;
    logic [7:0] INSTR_PC;
    logic       INSTR_VALID;
    logic       INSTR_READY;

    modport master (
        output ROM_ADDR,
        input  ROM_DATA,
        input  JUMP,
        input  JUMP_ADDR,
        output INSTR,
        output INSTR_PC,
        output INSTR_VALID,
        input  INSTR_READY
    );

    modport slave (
        input  ROM_ADDR,
        output ROM_DATA,
        output JUMP,
        output JUMP_ADDR,
        input  INSTR,
        input  INSTR_PC,
        input  INSTR_VALID,
        output INSTR_READY
    );
endinterface

// File: rtl/rom_fetch_unit.sv
// rtl/rom_fetch_unit.sv - sequential ROM prefetch into a show-ahead FIFO with jump flush
// Optional FETCH_DISCARD_CNT_EN adds the saturating DISCARD_CNT output.
module rom_fetch_unit #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    rom_fetch_unit_if.master  bus
`ifdef FETCH_DISCARD_CNT_EN
    ,
    output logic [15:0]       DISCARD_CNT
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    typedef enum logic {BOOT, RUN} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_rom_addr;
    logic [7:0]     r_pc;
    logic [7:0]     r_tag_d;
    logic           r_req_a;
    logic           r_req_d;
    logic [7:0]     r_mem_data [FIFO_DEPTH];
    logic [7:0]     r_mem_pc   [FIFO_DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           w_pop;
    logic           w_push;
    logic           w_issue;
    logic [SW-1:0]  w_pending;

    assign w_pop     = (r_count != '0) && bus.INSTR_READY;
    assign w_push    = r_req_d;
    // Reads already in flight reserve a FIFO slot so capture can never overflow.
    assign w_pending = SW'(r_count) + SW'(r_req_a) + SW'(r_req_d);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
                w_issue      = 1'b1;
            end
            RUN: begin
                w_issue = (w_pending < (SW'(FIFO_DEPTH) + SW'(w_pop)));
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rom_addr <= RESET_VECTOR;
            r_pc       <= RESET_VECTOR;
            r_tag_d    <= '0;
            r_req_a    <= 1'b0;
            r_req_d    <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (bus.JUMP) begin
            r_rom_addr <= bus.JUMP_ADDR;
            r_pc       <= bus.JUMP_ADDR + 8'd1;
            r_req_a    <= 1'b1;
            r_req_d    <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_req_d <= r_req_a;
            r_tag_d <= r_rom_addr;
            if (w_issue) begin
                r_rom_addr <= r_pc;
                r_pc       <= r_pc + 8'd1;
                r_req_a    <= 1'b1;
            end else begin
                r_req_a    <= 1'b0;
            end
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= bus.ROM_DATA;
                r_mem_pc[r_wr_ptr]   <= r_tag_d;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCH_DISCARD_CNT_EN
    logic [15:0] r_discard;
    logic [16:0] w_disc_sum;

    assign w_disc_sum = {1'b0, r_discard} + 17'(r_count) + 17'(r_req_a) + 17'(r_req_d);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_discard <= '0;
        end else if (bus.JUMP) begin
            r_discard <= w_disc_sum[16] ? 16'hFFFF : w_disc_sum[15:0];
        end
    end

    assign DISCARD_CNT = r_discard;
`endif

    assign bus.ROM_ADDR    = r_rom_addr;
    assign bus.INSTR       = r_mem_data[r_rd_ptr];
    assign bus.INSTR_PC    = r_mem_pc[r_rd_ptr];
    assign bus.INSTR_VALID = (r_count != '0);
endmodule
